cpu_decode_stage: RTL and testbench
===================================

Name: cpu_decode_stage

Overview:
- Registered RV32I decode stage between fetch and execute.
- Accepts instruction words over valid/ready and produces the 4-bit ALU control code, operand selects, immediate, register indices and memory/branch controls.
- One output register with backpressure and flush. This block is the producer of the ALU control encoding.

Parameters:
- XLEN, 32, datapath width for PC and immediate; immediates sign-extended to XLEN.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard held and incoming instruction (branch/trap redirect)
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  XLEN  PC of in_inst
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  registered PC
- out_alu_ctrl  out  4  ALU op code
- out_a_sel  out  2  operand_a source: 00 rs1, 01 PC, 10 zero
- out_b_imm  out  1  operand_b = imm (else rs2)
- out_imm  out  XLEN  sign-extended immediate
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_reg_write  out  1  writeback enable; forced 0 when rd = 0
- out_mem_read, out_mem_write  out  1 each  load/store
- out_funct3  out  3  mem size/sign or branch condition
- out_branch, out_jump  out  1 each  conditional branch; JAL/JALR

Behaviour:
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
- Shifts move operand_a by operand_b[4:0].
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in on in_valid && in_ready.
  - Transfer out on out_valid && out_ready.
  - Bundle is held stable while out_valid && !out_ready.
- Latency: one cycle. A bundle accepted at edge N is presented at out_* from edge N onward. Full throughput with out_ready tied high.
- Reset (rst_n low, async): out_valid 0; all out_* payload 0; in_ready therefore 1.
- Flush (sync, highest priority):
  - Next edge out_valid = 0; payload unchanged.
  - Input offered in the same cycle is dropped.
  - in_ready may be 1 during flush; the fetch side must treat it as consumed.
- Decode by opcode:
  - OP (0110011): funct3/funct7[5] → ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. a_sel rs1, b_imm 0.
  - OP-IMM (0010011): same map, b_imm 1. funct7[5] only selects SRA for funct3 101. No SUBI. I-imm.
  - LUI: ADD, a_sel zero, U-imm.
  - AUIPC: ADD, a_sel PC, U-imm.
  - JAL: jump, ADD, a_sel PC, b_imm, J-imm, reg_write.
  - JALR: jump, ADD, a_sel rs1, I-imm, reg_write.
  - BRANCH: SUB, a_sel rs1, b_imm 0, branch=1, B-imm, no reg_write. Execute uses ALU zero/less_than/unsigned_less_than per funct3.
  - LOAD: ADD, rs1+I-imm, mem_read, reg_write.
  - STORE: ADD, rs1+S-imm, mem_write, no reg_write.
  - MISC-MEM and SYSTEM: decoded as NOP (ADD, a_sel zero, b_imm 1, imm 0, all enables 0).
- Indices always extracted from fixed fields [19:15], [24:20], [11:7], whether used or not.
- Immediate bits per RV32I formats; bit 31 of the instruction is the sign bit for all formats.

Optional Feature:
- Macro: CPU_DECODE_ILLEGAL_EN.
- Enabled:
  - Extra output out_illegal (1 bit, reset 0), registered with the bundle.
  - Set for unknown opcode, inst[1:0] != 11, bad funct7 on OP/shift-imm, funct3 in {010,011,110,111} on BRANCH, undefined LOAD/STORE funct3.
  - Illegal bundles have all enables forced 0.
- Disabled: no port; illegal encodings decode as NOP.

Test Plan:
- Reset then 0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle out_valid 1, alu_ctrl 0, rs1 1, rs2 2, rd 3, b_imm 0, reg_write 1.
- 0xFFF00093 (addi x1,x0,-1) then 0x40335293 (srai x5,x6,3) back-to-back → imm 0xFFFFFFFF, ctrl 0; then ctrl 7, imm[4:0] 3, rd 5. One bundle per cycle.
- 0x00208463 (beq x1,x2,+8), in_pc 0x100 → ctrl 1, branch 1, imm 8, reg_write 0, out_pc 0x100.
- Backpressure: out_ready 0, offer two instructions → first held stable, in_ready 0, second waits. Raise out_ready → both delivered in order, none lost or duplicated.
- Flush with out_valid 1 and new in_valid → next cycle out_valid 0, new instruction never appears. Also assert rst_n low mid-stall → out_valid 0 immediately, without a clock edge.
- 0x00000000 → NOP bundle, all enables 0. With CPU_DECODE_ILLEGAL_EN defined, out_illegal 1.

Source files
------------

// File: rtl/cpu_decode_stage_if.sv
// rtl/cpu_decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
// Optional out_illegal present when CPU_DECODE_ILLEGAL_EN is defined.
interface cpu_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_alu_ctrl;
  logic [1:0]      out_a_sel;
  logic            out_b_imm;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic [2:0]      out_funct3;
  logic            out_branch;
  logic            out_jump;
`ifdef CPU_DECODE_ILLEGAL_EN
  logic            out_illegal;
`endif

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_alu_ctrl, out_a_sel, out_b_imm, out_imm,
           out_rs1, out_rs2, out_rd, out_reg_write, out_mem_read, out_mem_write,
           out_funct3, out_branch, out_jump
`ifdef CPU_DECODE_ILLEGAL_EN
    , output out_illegal
`endif
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_ctrl, out_a_sel, out_b_imm, out_imm,
           out_rs1, out_rs2, out_rd, out_reg_write, out_mem_read, out_mem_write,
           out_funct3, out_branch, out_jump
`ifdef CPU_DECODE_ILLEGAL_EN
    , input out_illegal
`endif
  );
endinterface

// File: rtl/cpu_decode_stage.sv
// rtl/cpu_decode_stage.sv - registered RV32I decode stage producing the ALU control encoding
// Optional illegal-instruction flag: CPU_DECODE_ILLEGAL_EN.
module cpu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  cpu_decode_stage_if.slave   bus
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111,
                         OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_MISC = 7'b0001111, OPC_SYSTEM = 7'b1110011;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] to_xlen(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  logic ill;
  always_comb begin
    ill = (inst[1:0] != 2'b11);
    case (opcode)
      OPC_OP:     if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))) ill = 1'b1;
      OPC_OPIMM:  if ((f3 == 3'b001 && f7 != 7'h00) ||
                      (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) ill = 1'b1;
      OPC_BRANCH: if (f3 == 3'b010 || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      OPC_LOAD:   if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      OPC_STORE:  if (f3[2] || f3 == 3'b011) ill = 1'b1;
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_MISC, OPC_SYSTEM: ;
      default:    ill = 1'b1;
    endcase
  end

  // Illegal encodings fall through as the NOP bundle (rs1-free ADD of zero + 0).
  logic [3:0]  d_alu;
  logic [1:0]  d_a_sel;
  logic        d_b_imm, d_rw, d_mr, d_mw, d_br, d_j;
  logic [31:0] d_imm;
  always_comb begin
    d_alu = ALU_ADD; d_a_sel = 2'b10; d_b_imm = 1'b1; d_imm = 32'd0;
    d_rw = 1'b0; d_mr = 1'b0; d_mw = 1'b0; d_br = 1'b0; d_j = 1'b0;
    if (!ill) begin
      case (opcode)
        OPC_OP:     begin d_alu = alu_of(f3, inst[30]); d_a_sel = 2'b00; d_b_imm = 1'b0; d_rw = 1'b1; end
        OPC_OPIMM:  begin d_alu = alu_of(f3, f3 == 3'b101 && inst[30]); d_a_sel = 2'b00;
                          d_imm = imm_i; d_rw = 1'b1; end
        OPC_LUI:    begin d_imm = imm_u; d_rw = 1'b1; end
        OPC_AUIPC:  begin d_a_sel = 2'b01; d_imm = imm_u; d_rw = 1'b1; end
        OPC_JAL:    begin d_a_sel = 2'b01; d_imm = imm_j; d_rw = 1'b1; d_j = 1'b1; end
        OPC_JALR:   begin d_a_sel = 2'b00; d_imm = imm_i; d_rw = 1'b1; d_j = 1'b1; end
        OPC_BRANCH: begin d_alu = ALU_SUB; d_a_sel = 2'b00; d_b_imm = 1'b0; d_imm = imm_b; d_br = 1'b1; end
        OPC_LOAD:   begin d_a_sel = 2'b00; d_imm = imm_i; d_mr = 1'b1; d_rw = 1'b1; end
        OPC_STORE:  begin d_a_sel = 2'b00; d_imm = imm_s; d_mw = 1'b1; end
        default: ;
      endcase
    end
    if (inst[11:7] == 5'd0) d_rw = 1'b0;
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0; bus.out_pc <= '0; bus.out_alu_ctrl <= '0; bus.out_a_sel <= '0;
      bus.out_b_imm <= 1'b0; bus.out_imm <= '0; bus.out_rs1 <= '0; bus.out_rs2 <= '0;
      bus.out_rd <= '0; bus.out_reg_write <= 1'b0; bus.out_mem_read <= 1'b0;
      bus.out_mem_write <= 1'b0; bus.out_funct3 <= '0; bus.out_branch <= 1'b0; bus.out_jump <= 1'b0;
`ifdef CPU_DECODE_ILLEGAL_EN
      bus.out_illegal <= 1'b0;
`endif
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid && bus.in_ready) begin
      bus.out_valid <= 1'b1; bus.out_pc <= bus.in_pc; bus.out_alu_ctrl <= d_alu;
      bus.out_a_sel <= d_a_sel; bus.out_b_imm <= d_b_imm; bus.out_imm <= to_xlen(d_imm);
      bus.out_rs1 <= inst[19:15]; bus.out_rs2 <= inst[24:20]; bus.out_rd <= inst[11:7];
      bus.out_reg_write <= d_rw; bus.out_mem_read <= d_mr; bus.out_mem_write <= d_mw;
      bus.out_funct3 <= f3; bus.out_branch <= d_br; bus.out_jump <= d_j;
`ifdef CPU_DECODE_ILLEGAL_EN
      bus.out_illegal <= ill;
`endif
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_decode_stage.sv
// tb/tb_cpu_decode_stage.sv - randomized and directed checks of cpu_decode_stage against a reference decoder
module tb_cpu_decode_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  cpu_decode_stage_if #(.XLEN(XLEN)) bus ();
  cpu_decode_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  a_sel;
    logic        b_imm, rw, mr, mw, br, j, ill;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
  } bundle_t;

  int errors = 0;
  int checks = 0;
  bundle_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    bundle_t b;
    int s;
    int alu_tab[8];
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    bit legal;
    alu_tab = '{0, 5, 8, 9, 4, 6, 3, 2};
    s  = $signed(inst);
    op = inst[6:0];
    f3 = inst[14:12];
    f7 = inst[31:25];
    b.pc = pc; b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.rd = inst[11:7]; b.f3 = f3;
    b.alu = 4'd0; b.a_sel = 2'd2; b.b_imm = 1'b1; b.imm = 32'd0;
    b.rw = 1'b0; b.mr = 1'b0; b.mw = 1'b0; b.br = 1'b0; b.j = 1'b0;
    case (op)
      7'h33:   legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      7'h13:   legal = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      7'h63:   legal = !(f3 inside {3'd2, 3'd3, 3'd6, 3'd7});
      7'h03:   legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      7'h23:   legal = (f3 <= 3'd2);
      7'h37, 7'h17, 7'h6f, 7'h67, 7'h0f, 7'h73: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    if (inst[1:0] != 2'b11) legal = 1'b0;
    b.ill = !legal;
    if (legal) begin
      case (op)
        7'h33: begin b.alu = 4'(alu_tab[f3] + int'(inst[30] && (f3 == 0 || f3 == 5))); b.a_sel = 0; b.b_imm = 0; b.rw = 1; end
        7'h13: begin b.alu = 4'(alu_tab[f3] + int'(inst[30] && f3 == 5)); b.a_sel = 0; b.imm = 32'(s >>> 20); b.rw = 1; end
        7'h37: begin b.imm = inst & 32'hFFFFF000; b.rw = 1; end
        7'h17: begin b.a_sel = 1; b.imm = inst & 32'hFFFFF000; b.rw = 1; end
        7'h6f: begin b.a_sel = 1; b.j = 1; b.rw = 1;
                 b.imm = 32'((s >>> 31) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2); end
        7'h67: begin b.a_sel = 0; b.j = 1; b.rw = 1; b.imm = 32'(s >>> 20); end
        7'h63: begin b.alu = 1; b.a_sel = 0; b.b_imm = 0; b.br = 1;
                 b.imm = 32'((s >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2); end
        7'h03: begin b.a_sel = 0; b.mr = 1; b.rw = 1; b.imm = 32'(s >>> 20); end
        7'h23: begin b.a_sel = 0; b.mw = 1; b.imm = 32'((s >>> 25) * 32 + int'(inst[11:7])); end
        default: ;
      endcase
    end
    if (b.rd == 0) b.rw = 1'b0;
    return b;
  endfunction

  task automatic cmp_bundle(input string tag, input bundle_t e);
    check({tag, ".pc"},    64'(bus.out_pc),        64'(e.pc));
    check({tag, ".alu"},   64'(bus.out_alu_ctrl),  64'(e.alu));
    check({tag, ".a_sel"}, 64'(bus.out_a_sel),     64'(e.a_sel));
    check({tag, ".b_imm"}, 64'(bus.out_b_imm),     64'(e.b_imm));
    check({tag, ".imm"},   64'(bus.out_imm),       64'(e.imm));
    check({tag, ".rs1"},   64'(bus.out_rs1),       64'(e.rs1));
    check({tag, ".rs2"},   64'(bus.out_rs2),       64'(e.rs2));
    check({tag, ".rd"},    64'(bus.out_rd),        64'(e.rd));
    check({tag, ".rw"},    64'(bus.out_reg_write), 64'(e.rw));
    check({tag, ".mr"},    64'(bus.out_mem_read),  64'(e.mr));
    check({tag, ".mw"},    64'(bus.out_mem_write), 64'(e.mw));
    check({tag, ".f3"},    64'(bus.out_funct3),    64'(e.f3));
    check({tag, ".br"},    64'(bus.out_branch),    64'(e.br));
    check({tag, ".j"},     64'(bus.out_jump),      64'(e.j));
`ifdef CPU_DECODE_ILLEGAL_EN
    check({tag, ".ill"},   64'(bus.out_illegal),   64'(e.ill));
`endif
  endtask

  // One clock: drive at the falling edge, check what the register holds, then advance the model.
  task automatic cycle(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit rdy;
    @(negedge clk);
    bus.in_valid = iv; bus.in_inst = inst; bus.in_pc = pc; bus.out_ready = ordy; flush = fl;
    #1;
    rdy = (exp_q.size() == 0) || ordy;
    check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
    if (exp_q.size() != 0) cmp_bundle("out", exp_q[0]);
    if (fl) exp_q.delete();
    else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (iv && rdy) exp_q.push_back(ref_decode(inst, pc));
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [6:0] ops[11];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0f, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 11) != 0) begin
      w[6:0] = ops[$urandom_range(0, 10)];
      if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
        w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    #12;
    check("rst.valid", 64'(bus.out_valid), 64'd0);
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.alu", 64'(bus.out_alu_ctrl), 64'd0);
    check("rst.a_sel", 64'(bus.out_a_sel), 64'd0);
    check("rst.b_imm", 64'(bus.out_b_imm), 64'd0);
    check("rst.imm", 64'(bus.out_imm), 64'd0);
    check("rst.pc", 64'(bus.out_pc), 64'd0);
    check("rst.rw", 64'(bus.out_reg_write), 64'd0);
`ifdef CPU_DECODE_ILLEGAL_EN
    check("rst.ill", 64'(bus.out_illegal), 64'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    cycle(1, 32'h002081B3, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("add.valid", 64'(bus.out_valid), 64'd1);
    check("add.alu", 64'(bus.out_alu_ctrl), 64'd0);
    check("add.rs1", 64'(bus.out_rs1), 64'd1);
    check("add.rs2", 64'(bus.out_rs2), 64'd2);
    check("add.rd", 64'(bus.out_rd), 64'd3);
    check("add.b_imm", 64'(bus.out_b_imm), 64'd0);
    check("add.rw", 64'(bus.out_reg_write), 64'd1);

    cycle(1, 32'hFFF00093, 32'h4, 1, 0);
    cycle(1, 32'h40335293, 32'h8, 1, 0);
    check("addi.imm", 64'(bus.out_imm), 64'hFFFFFFFF);
    check("addi.alu", 64'(bus.out_alu_ctrl), 64'd0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("srai.valid", 64'(bus.out_valid), 64'd1);
    check("srai.alu", 64'(bus.out_alu_ctrl), 64'd7);
    check("srai.shamt", 64'(bus.out_imm[4:0]), 64'd3);
    check("srai.rd", 64'(bus.out_rd), 64'd5);

    cycle(1, 32'h00208463, 32'h100, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("beq.alu", 64'(bus.out_alu_ctrl), 64'd1);
    check("beq.br", 64'(bus.out_branch), 64'd1);
    check("beq.imm", 64'(bus.out_imm), 64'd8);
    check("beq.rw", 64'(bus.out_reg_write), 64'd0);
    check("beq.pc", 64'(bus.out_pc), 64'h100);

    cycle(1, 32'h00A00513, 32'h200, 0, 0);
    cycle(1, 32'h00B00593, 32'h204, 0, 0);
    check("bp.in_ready", 64'(bus.in_ready), 64'd0);
    check("bp.rd_first", 64'(bus.out_rd), 64'd10);
    cycle(1, 32'h00B00593, 32'h204, 0, 0);
    cycle(1, 32'h00B00593, 32'h204, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("bp.rd_second", 64'(bus.out_rd), 64'd11);
    cycle(0, 32'h0, 32'h0, 1, 0);

    cycle(1, 32'h00C00613, 32'h300, 0, 0);
    cycle(1, 32'h00D00693, 32'h304, 0, 1);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("flush.valid", 64'(bus.out_valid), 64'd0);
    check("flush.payload", 64'(bus.out_rd), 64'd12);
    cycle(0, 32'h0, 32'h0, 1, 0);

    cycle(1, 32'h00E00713, 32'h400, 0, 0);
    cycle(0, 32'h0, 32'h0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("arst.valid", 64'(bus.out_valid), 64'd0);
    check("arst.in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;

    cycle(1, 32'h00000000, 32'h500, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("nop.rw", 64'(bus.out_reg_write), 64'd0);
    check("nop.mr", 64'(bus.out_mem_read), 64'd0);
    check("nop.mw", 64'(bus.out_mem_write), 64'd0);
    check("nop.br", 64'(bus.out_branch), 64'd0);
    check("nop.j", 64'(bus.out_jump), 64'd0);
`ifdef CPU_DECODE_ILLEGAL_EN
    check("nop.ill", 64'(bus.out_illegal), 64'd1);
`endif

    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, gen_inst(), $urandom & 32'hFFFFFFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
